// File: rtl/banked_reg_file_if.sv
// Port bundle for banked_reg_file: write ports A/B, read ports A/B, bank-clear control and status.
// slave is the register file side; master is the requester side.
interface banked_reg_file_if #(
    parameter int DATA_W        = 16,
    parameter int REGS_PER_BANK = 32,
    parameter int NUM_BANKS     = 4
);
    localparam int ADDR_W = $clog2(REGS_PER_BANK);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic [BANK_W-1:0] bankSelect_i;

    logic              wrAEn_i;
    logic [ADDR_W-1:0] wrAAddr_i;
    logic [DATA_W-1:0] wrAData_i;
    logic              wrBEn_i;
    logic [ADDR_W-1:0] wrBAddr_i;
    logic [DATA_W-1:0] wrBData_i;

    logic              rdAEn_i;
    logic [ADDR_W-1:0] rdAPrimAddr_i;
    logic              rdASecIsReg_i;
    logic [DATA_W-1:0] rdASec_i;
    logic [DATA_W-1:0] rdAPrim_o;
    logic [DATA_W-1:0] rdASec_o;
    logic              rdAValid_o;

    logic              rdBEn_i;
    logic [ADDR_W-1:0] rdBPrimAddr_i;
    logic              rdBSecIsReg_i;
    logic [DATA_W-1:0] rdBSec_i;
    logic [DATA_W-1:0] rdBPrim_o;
    logic [DATA_W-1:0] rdBSec_o;
    logic              rdBValid_o;

    logic              clearBank_i;
    logic [BANK_W-1:0] clearBankSel_i;
    logic              busy_o;
    logic              wrDropped_o;

    modport master (
        output bankSelect_i,
        output wrAEn_i, wrAAddr_i, wrAData_i,
        output wrBEn_i, wrBAddr_i, wrBData_i,
        output rdAEn_i, rdAPrimAddr_i, rdASecIsReg_i, rdASec_i,
        input  rdAPrim_o, rdASec_o, rdAValid_o,
        output rdBEn_i, rdBPrimAddr_i, rdBSecIsReg_i, rdBSec_i,
        input  rdBPrim_o, rdBSec_o, rdBValid_o,
        output clearBank_i, clearBankSel_i,
        input  busy_o, wrDropped_o
    );

    modport slave (
        input  bankSelect_i,
        input  wrAEn_i, wrAAddr_i, wrAData_i,
        input  wrBEn_i, wrBAddr_i, wrBData_i,
        input  rdAEn_i, rdAPrimAddr_i, rdASecIsReg_i, rdASec_i,
        output rdAPrim_o, rdASec_o, rdAValid_o,
        input  rdBEn_i, rdBPrimAddr_i, rdBSecIsReg_i, rdBSec_i,
        output rdBPrim_o, rdBSec_o, rdBValid_o,
        input  clearBank_i, clearBankSel_i,
        output busy_o, wrDropped_o
    );
endinterface

// File: rtl/banked_reg_file.sv
// Banked register file, 2 write + 2 read ports, write-first bypass (B wins), sequential bank clear.
// Latency: reads registered, 1 cycle; clear occupies REGS_PER_BANK cycles.
// Backpressure: none; port writes during a clear are discarded and flagged on wrDropped_o.
module banked_reg_file #(
    parameter int DATA_W        = 16,
    parameter int REGS_PER_BANK = 32,
    parameter int NUM_BANKS     = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    banked_reg_file_if.slave bus
);
    localparam int ADDR_W   = $clog2(REGS_PER_BANK);
    localparam int BANK_W   = $clog2(NUM_BANKS);
    localparam int IDX_W    = BANK_W + ADDR_W;
    localparam int NUM_REGS = NUM_BANKS * REGS_PER_BANK;

    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

    clr_state_t        state, state_nxt;
    logic [BANK_W-1:0] clr_bank;
    logic [ADDR_W-1:0] clr_idx;
    logic [IDX_W-1:0]  clr_ptr;
    logic              busy;
    logic              clr_last;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              wr_a_ok, wr_b_ok;
    logic [IDX_W-1:0]  wr_a_idx, wr_b_idx;

    logic [DATA_W-1:0] a_prim_val, a_sec_val, b_prim_val, b_sec_val;
    logic [DATA_W-1:0] a_prim_q, a_sec_q, b_prim_q, b_sec_q;
    logic              a_vld_q, b_vld_q, wr_drop_q;

    assign busy     = (state == ST_CLEAR);
    assign clr_last = &clr_idx;
    assign clr_ptr  = {clr_bank, clr_idx};
    assign wr_a_ok  = bus.wrAEn_i & ~busy;
    assign wr_b_ok  = bus.wrBEn_i & ~busy;
    assign wr_a_idx = {bus.bankSelect_i, bus.wrAAddr_i};
    assign wr_b_idx = {bus.bankSelect_i, bus.wrBAddr_i};

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.clearBank_i) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_last)        state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Target bank is latched only in IDLE, so a clear request during CLEAR has no effect.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            clr_bank <= '0;
            clr_idx  <= '0;
        end else if (state == ST_IDLE) begin
            if (bus.clearBank_i) clr_bank <= bus.clearBankSel_i;
            clr_idx <= '0;
        end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (wr_a_ok) regs[wr_a_idx] <= bus.wrAData_i;
            if (wr_b_ok) regs[wr_b_idx] <= bus.wrBData_i;
            if (busy)    regs[clr_ptr]  <= '0;
        end
    end

    // Same-cycle port writes are forwarded; the clear's zeroing deliberately is not.
    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] addr);
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] val;
        idx = {bus.bankSelect_i, addr};
        val = regs[idx];
        if (wr_b_ok && (wr_b_idx == idx))      val = bus.wrBData_i;
        else if (wr_a_ok && (wr_a_idx == idx)) val = bus.wrAData_i;
        return val;
    endfunction

    always_comb begin
        a_prim_val = fwd(bus.rdAPrimAddr_i);
        a_sec_val  = bus.rdASecIsReg_i ? fwd(bus.rdASec_i[ADDR_W-1:0]) : bus.rdASec_i;
        b_prim_val = fwd(bus.rdBPrimAddr_i);
        b_sec_val  = bus.rdBSecIsReg_i ? fwd(bus.rdBSec_i[ADDR_W-1:0]) : bus.rdBSec_i;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            a_prim_q  <= '0;
            a_sec_q   <= '0;
            b_prim_q  <= '0;
            b_sec_q   <= '0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            a_vld_q   <= bus.rdAEn_i;
            b_vld_q   <= bus.rdBEn_i;
            wr_drop_q <= busy & (bus.wrAEn_i | bus.wrBEn_i);
            if (bus.rdAEn_i) begin
                a_prim_q <= a_prim_val;
                a_sec_q  <= a_sec_val;
            end
            if (bus.rdBEn_i) begin
                b_prim_q <= b_prim_val;
                b_sec_q  <= b_sec_val;
            end
        end
    end

    assign bus.rdAPrim_o   = a_prim_q;
    assign bus.rdASec_o    = a_sec_q;
    assign bus.rdAValid_o  = a_vld_q;
    assign bus.rdBPrim_o   = b_prim_q;
    assign bus.rdBSec_o    = b_sec_q;
    assign bus.rdBValid_o  = b_vld_q;
    assign bus.busy_o      = busy;
    assign bus.wrDropped_o = wr_drop_q;
endmodule

// File: tb/tb_banked_reg_file.sv
// Scoreboard bench for banked_reg_file: reference memory model, expected reads queued at drive time.
module tb_banked_reg_file;
    localparam int DATA_W = 16;
    localparam int RPB    = 32;
    localparam int NB     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    banked_reg_file_if #(.DATA_W(DATA_W), .REGS_PER_BANK(RPB), .NUM_BANKS(NB)) bus ();

    banked_reg_file #(.DATA_W(DATA_W), .REGS_PER_BANK(RPB), .NUM_BANKS(NB)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [15:0] prim;
        logic [15:0] sec;
    } rd_t;

    logic [15:0] model [NB*RPB];
    bit          m_busy;
    logic [1:0]  m_bank;
    int          m_cnt;
    rd_t         q_a[$], q_b[$];
    logic [15:0] last_a_prim, last_a_sec, last_b_prim, last_b_sec;
    int          n_checks = 0;
    int          n_errors = 0;
    int          busy_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] peek(input logic [4:0] addr);
        logic [15:0] v;
        v = model[{bus.bankSelect_i, addr}];
        if (!m_busy) begin
            if (bus.wrAEn_i && bus.wrAAddr_i == addr) v = bus.wrAData_i;
            if (bus.wrBEn_i && bus.wrBAddr_i == addr) v = bus.wrBData_i;
        end
        return v;
    endfunction

    task automatic idle();
        bus.wrAEn_i = 0; bus.wrAAddr_i = '0; bus.wrAData_i = '0;
        bus.wrBEn_i = 0; bus.wrBAddr_i = '0; bus.wrBData_i = '0;
        bus.rdAEn_i = 0; bus.rdAPrimAddr_i = '0; bus.rdASecIsReg_i = 0; bus.rdASec_i = '0;
        bus.rdBEn_i = 0; bus.rdBPrimAddr_i = '0; bus.rdBSecIsReg_i = 0; bus.rdBSec_i = '0;
        bus.clearBank_i = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB*RPB; i++) model[i] = '0;
        m_busy = 0; m_bank = '0; m_cnt = 0;
        q_a.delete(); q_b.delete();
        last_a_prim = '0; last_a_sec = '0; last_b_prim = '0; last_b_sec = '0;
    endtask

    // One clock: queue expected reads, advance the model, then compare after the edge.
    task automatic step();
        bit  en_a, en_b, exp_drop;
        rd_t ra, rb;
        en_a = bus.rdAEn_i;
        en_b = bus.rdBEn_i;
        if (en_a) begin
            ra.prim = peek(bus.rdAPrimAddr_i);
            ra.sec  = bus.rdASecIsReg_i ? peek(bus.rdASec_i[4:0]) : bus.rdASec_i;
            q_a.push_back(ra);
        end
        if (en_b) begin
            rb.prim = peek(bus.rdBPrimAddr_i);
            rb.sec  = bus.rdBSecIsReg_i ? peek(bus.rdBSec_i[4:0]) : bus.rdBSec_i;
            q_b.push_back(rb);
        end
        exp_drop = m_busy && (bus.wrAEn_i || bus.wrBEn_i);
        if (!m_busy) begin
            if (bus.wrAEn_i) model[{bus.bankSelect_i, bus.wrAAddr_i}] = bus.wrAData_i;
            if (bus.wrBEn_i) model[{bus.bankSelect_i, bus.wrBAddr_i}] = bus.wrBData_i;
        end
        if (m_busy) begin
            model[{m_bank, m_cnt[4:0]}] = '0;
            m_cnt++;
            if (m_cnt == RPB) m_busy = 0;
        end else if (bus.clearBank_i) begin
            m_busy = 1; m_bank = bus.clearBankSel_i; m_cnt = 0;
        end
        @(posedge clk); #1;
        check("busy", bus.busy_o, m_busy);
        check("wr_dropped", bus.wrDropped_o, exp_drop);
        check("rd_a_valid", bus.rdAValid_o, en_a);
        check("rd_b_valid", bus.rdBValid_o, en_b);
        if (en_a) begin
            if (q_a.size() == 0) check("q_a_underflow", 1, 0);
            else begin ra = q_a.pop_front(); last_a_prim = ra.prim; last_a_sec = ra.sec; end
        end
        if (en_b) begin
            if (q_b.size() == 0) check("q_b_underflow", 1, 0);
            else begin rb = q_b.pop_front(); last_b_prim = rb.prim; last_b_sec = rb.sec; end
        end
        check("rd_a_prim", bus.rdAPrim_o, last_a_prim);
        check("rd_a_sec",  bus.rdASec_o,  last_a_sec);
        check("rd_b_prim", bus.rdBPrim_o, last_b_prim);
        check("rd_b_sec",  bus.rdBSec_o,  last_b_sec);
    endtask

    task automatic fill_all();
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < RPB/2; i++) begin
                idle();
                bus.bankSelect_i = 2'(b);
                bus.wrAEn_i = 1; bus.wrAAddr_i = 5'(i);      bus.wrAData_i = 16'($urandom_range(1, 65535));
                bus.wrBEn_i = 1; bus.wrBAddr_i = 5'(i + 16); bus.wrBData_i = 16'($urandom_range(1, 65535));
                step();
            end
        end
        idle();
    endtask

    task automatic read_all(input bit all_zero, input int zero_bank);
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < RPB/2; i++) begin
                idle();
                bus.bankSelect_i  = 2'(b);
                bus.rdAEn_i       = 1; bus.rdAPrimAddr_i = 5'(i);
                bus.rdASecIsReg_i = 1; bus.rdASec_i = (16'($urandom) & 16'hFFE0) | 16'(i + 16);
                bus.rdBEn_i       = 1; bus.rdBPrimAddr_i = 5'(i + 16);
                bus.rdBSecIsReg_i = 0; bus.rdBSec_i = 16'($urandom);
                step();
                if (all_zero || b == zero_bank) begin
                    check("zero_a_prim", bus.rdAPrim_o, 0);
                    check("zero_a_sec",  bus.rdASec_o,  0);
                    check("zero_b_prim", bus.rdBPrim_o, 0);
                end
            end
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.bankSelect_i   = '0;
        bus.clearBankSel_i = '0;
        model_reset();
        #12;
        check("rst_a_prim", bus.rdAPrim_o, 0);
        check("rst_a_valid", bus.rdAValid_o, 0);
        check("rst_b_sec", bus.rdBSec_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_drop", bus.wrDropped_o, 0);
        @(negedge clk); rst_n = 1;
        step();

        // Write bank 1 reg 5, read it back, and confirm bank 0 reg 5 is separate.
        idle(); bus.bankSelect_i = 1;
        bus.wrAEn_i = 1; bus.wrAAddr_i = 5; bus.wrAData_i = 16'h1234;
        step();
        idle(); bus.bankSelect_i = 1; bus.rdAEn_i = 1; bus.rdAPrimAddr_i = 5;
        step();
        check("b1_r5", bus.rdAPrim_o, 16'h1234);
        idle(); bus.bankSelect_i = 0; bus.rdAEn_i = 1; bus.rdAPrimAddr_i = 5;
        step();
        check("b0_r5", bus.rdAPrim_o, 16'h0000);

        // Same-register collision with same-cycle read on port B.
        idle(); bus.bankSelect_i = 0;
        bus.wrAEn_i = 1; bus.wrAAddr_i = 3; bus.wrAData_i = 16'hAAAA;
        bus.wrBEn_i = 1; bus.wrBAddr_i = 3; bus.wrBData_i = 16'hBBBB;
        bus.rdBEn_i = 1; bus.rdBPrimAddr_i = 3;
        step();
        check("collide_bypass", bus.rdBPrim_o, 16'hBBBB);
        idle(); bus.rdAEn_i = 1; bus.rdAPrimAddr_i = 3;
        step();
        check("collide_stored", bus.rdAPrim_o, 16'hBBBB);

        // Secondary operand as immediate and as register (upper bits ignored).
        idle(); bus.wrAEn_i = 1; bus.wrAAddr_i = 5; bus.wrAData_i = 16'h5555;
        step();
        idle(); bus.rdAEn_i = 1; bus.rdASecIsReg_i = 0; bus.rdASec_i = 16'hBEEF;
        step();
        check("sec_imm", bus.rdASec_o, 16'hBEEF);
        idle(); bus.rdAEn_i = 1; bus.rdASecIsReg_i = 1; bus.rdASec_i = 16'h0025;
        step();
        check("sec_reg", bus.rdASec_o, 16'h5555);
        idle();
        step();
        check("hold_valid", bus.rdAValid_o, 0);
        check("hold_sec", bus.rdASec_o, 16'h5555);

        // Mixed random traffic.
        for (int n = 0; n < 60; n++) begin
            bus.bankSelect_i  = 2'($urandom_range(0, 3));
            bus.wrAEn_i       = 1'($urandom_range(0, 1));
            bus.wrAAddr_i     = 5'($urandom_range(0, 31));
            bus.wrAData_i     = 16'($urandom);
            bus.wrBEn_i       = 1'($urandom_range(0, 1));
            bus.wrBAddr_i     = 5'($urandom_range(0, 31));
            bus.wrBData_i     = 16'($urandom);
            bus.rdAEn_i       = 1'($urandom_range(0, 1));
            bus.rdAPrimAddr_i = 5'($urandom_range(0, 31));
            bus.rdASecIsReg_i = 1'($urandom_range(0, 1));
            bus.rdASec_i      = 16'($urandom);
            bus.rdBEn_i       = 1'($urandom_range(0, 1));
            bus.rdBPrimAddr_i = 5'($urandom_range(0, 31));
            bus.rdBSecIsReg_i = 1'($urandom_range(0, 1));
            bus.rdBSec_i      = 16'($urandom);
            step();
        end
        idle();

        // Clear bank 2 from full, with a same-cycle write into bank 2 that must end up zero.
        fill_all();
        bus.bankSelect_i = 2;
        bus.wrAEn_i = 1; bus.wrAAddr_i = 9; bus.wrAData_i = 16'h9999;
        bus.clearBank_i = 1; bus.clearBankSel_i = 2;
        step();
        idle();
        busy_cnt = bus.busy_o ? 1 : 0;
        for (int i = 0; i < 100 && bus.busy_o; i++) begin
            if (i == 4) begin
                bus.bankSelect_i = 0;
                bus.wrAEn_i = 1; bus.wrAAddr_i = 7; bus.wrAData_i = 16'hDEAD;
                bus.wrBEn_i = 1; bus.wrBAddr_i = 8; bus.wrBData_i = 16'hF00D;
                bus.clearBank_i = 1; bus.clearBankSel_i = 3;
            end
            if (i == 6) begin
                bus.bankSelect_i = 2;
                bus.rdAEn_i = 1; bus.rdAPrimAddr_i = 31;
                bus.rdBEn_i = 1; bus.rdBPrimAddr_i = 0;
            end
            step();
            if (i == 4) check("drop_pulse", bus.wrDropped_o, 1);
            if (i == 6) check("clr_done_r0", bus.rdBPrim_o, 0);
            idle();
            if (bus.busy_o) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, 32);
        step();
        check("drop_one_shot", bus.wrDropped_o, 0);
        read_all(0, 2);

        // Reset in the middle of a clear.
        fill_all();
        bus.bankSelect_i = 1; bus.rdAEn_i = 1; bus.rdAPrimAddr_i = 5;
        bus.clearBank_i = 1; bus.clearBankSel_i = 2;
        step();
        bus.clearBank_i = 0;
        for (int i = 0; i < 9; i++) step();
        idle();
        #1 rst_n = 0;
        #1;
        check("mid_rst_busy", bus.busy_o, 0);
        check("mid_rst_a_prim", bus.rdAPrim_o, 0);
        check("mid_rst_a_valid", bus.rdAValid_o, 0);
        check("mid_rst_b_prim", bus.rdBPrim_o, 0);
        check("mid_rst_drop", bus.wrDropped_o, 0);
        model_reset();
        @(negedge clk); rst_n = 1;
        step();
        read_all(1, -1);

        check("queues_empty", q_a.size() + q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/banked_reg_file.md
BANKED_REG_FILE -- requirements
Module: banked_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter REGS_PER_BANK, default 32, registers per bank; power of two, at least 2.
REQ-003 SHALL have parameter NUM_BANKS, default 4, number of banks; power of two, at least 2.
REQ-004 SHALL derive local widths ADDR_W = clog2(REGS_PER_BANK) and BANK_W = clog2(NUM_BANKS).
REQ-005 SHALL have clock_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have reset_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have bankSelect_i, input, BANK_W bits: active bank for all port accesses.
REQ-008 SHALL have, for X in {A,B}, wrXEn_i, input, 1 bit: write enable.
REQ-009 SHALL have wrXAddr_i, input, ADDR_W bits, and wrXData_i, input, DATA_W bits: write address and write data.
REQ-010 SHALL have rdXEn_i, input, 1 bit, and rdXPrimAddr_i, input, ADDR_W bits: read enable and primary read address.
REQ-011 SHALL have rdXSecIsReg_i, input, 1 bit, and rdXSec_i, input, DATA_W bits: secondary operand, either a register address or an immediate.
REQ-012 SHALL have rdXPrim_o and rdXSec_o, output, DATA_W bits each, and rdXValid_o, output, 1 bit.
REQ-013 SHALL have clearBank_i, input, 1 bit, and clearBankSel_i, input, BANK_W bits: bank-clear request and target bank.
REQ-014 SHALL have busy_o, output, 1 bit (clear in progress), and wrDropped_o, output, 1 bit (write discarded).

Function
REQ-015 SHALL store NUM_BANKS*REGS_PER_BANK registers; physical index = bankSelect_i*REGS_PER_BANK + address.
REQ-016 SHALL write wrXData_i on the clock edge when wrXEn_i=1 and busy_o=0.
REQ-017 SHALL apply port B only when A and B write the same physical register in one cycle.
REQ-018 SHALL register reads with 1-cycle latency: rdXEn_i=1 at edge N gives rdXPrim_o, rdXSec_o and rdXValid_o=1 after edge N.
REQ-019 SHALL drop rdXValid_o to 0 after any edge where rdXEn_i=0, and hold rdXPrim_o and rdXSec_o unchanged.
REQ-020 SHALL, when rdXSecIsReg_i=1, return the register addressed by rdXSec_i[ADDR_W-1:0] in the active bank; upper bits ignored.
REQ-021 SHALL, when rdXSecIsReg_i=0, pass rdXSec_i unchanged as an immediate.
REQ-022 SHALL bypass write-first: a read of a register written in the same cycle returns the new data, B data when A and B collide.
REQ-023 SHALL implement clear FSM IDLE -> CLEAR -> IDLE: clearBank_i=1 in IDLE captures clearBankSel_i and enters CLEAR at the next edge.
REQ-024 SHALL in CLEAR zero one register per cycle at index 0..REGS_PER_BANK-1 of the captured bank, then return to IDLE.
REQ-025 SHALL hold busy_o=1 for exactly REGS_PER_BANK cycles, i.e. throughout CLEAR.
REQ-026 SHALL ignore clearBank_i while busy_o=1.
REQ-027 SHALL accept a write in the same cycle as clearBank_i; that write is then zeroed if it targets the cleared bank.
REQ-028 SHALL discard port writes while busy_o=1 and pulse wrDropped_o=1 for one cycle per cycle with any write dropped.
REQ-029 SHALL serve reads normally during CLEAR; registers not yet cleared return their old contents.
REQ-030 SHALL not bypass the zeroing done by the clear FSM.

Reset
REQ-031 SHALL, on reset_i=0 and independent of the clock, zero all registers and all outputs and force the FSM to IDLE.
REQ-032 SHALL abort a clear in progress on reset; after reset release no partial-clear state remains and busy_o=0.
REQ-033 SHALL perform no write, read or clear on the first edge after reset release unless enables are high at that edge.

Verification
REQ-034 Bench SHALL cover: bank 1, wrAAddr 5 = 16'h1234; next cycle bank 1 rdAPrimAddr 5 -> 16'h1234; bank 0 addr 5 -> 0.
REQ-035 Bench SHALL cover: A and B both write bank 0 reg 3 (16'hAAAA, 16'hBBBB) while rdB reads reg 3 -> rdBPrim_o=16'hBBBB next cycle and stored 16'hBBBB.
REQ-036 Bench SHALL cover: rdASecIsReg=0, rdASec=16'hBEEF -> rdASec_o=16'hBEEF; rdASecIsReg=1, rdASec=16'h0025 -> reg 5 contents.
REQ-037 Bench SHALL cover: clear bank 2 from full -> busy_o high exactly 32 cycles; bank 2 all zero; banks 0, 1 and 3 untouched.
REQ-038 Bench SHALL cover: write during busy_o -> wrDropped_o pulses, register unchanged; clearBank_i during busy ignored.
REQ-039 Bench SHALL cover: reset_i low mid-clear (cycle 10) -> immediate zero outputs, busy_o=0, all registers 0.
